dehaze_pipe: RTL

DEHAZE_PIPE -- requirements
Module: dehaze_pipe

---
 rtl/dehaze_pipe_if.sv | 27 ++
 rtl/dehaze_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dehaze_pipe_if.sv
// Video bus for dehaze_pipe: hazy pixel stream in, processed stream out.
// master drives the input side, slave is the pipeline.
interface dehaze_pipe_if #(
  parameter int DW = 8
);
  logic [3*DW-1:0] i_rgb;
  logic            i_hsync;
  logic            i_vsync;
  logic            i_de;
  logic [DW-1:0]   i_thre;
  logic [1:0]      i_mode;
  logic [3*DW-1:0] o_rgb;
  logic            o_hsync;
  logic            o_vsync;
  logic            o_de;
  logic [DW-1:0]   o_atmos;

  modport master (
    output i_rgb, i_hsync, i_vsync, i_de, i_thre, i_mode,
    input  o_rgb, o_hsync, o_vsync, o_de, o_atmos
  );

  modport slave (
    input  i_rgb, i_hsync, i_vsync, i_de, i_thre, i_mode,
    output o_rgb, o_hsync, o_vsync, o_de, o_atmos
  );
endinterface

// File: rtl/dehaze_pipe.sv
// Dark-channel-prior dehaze, 5-stage pipeline.
// Atmospheric light and mode are latched once per frame.
module dehaze_pipe #(
  parameter int DW       = 8,
  parameter int OMEGA_Q8 = 243,
  parameter int T_MIN    = 26,
  parameter int FRAC     = 12
) (
  input logic           pixelclk,
  input logic           reset_n,
  dehaze_pipe_if.slave  vif
);
  localparam int MAXV = (1 << DW) - 1;
  localparam int RW   = DW + FRAC;
  localparam int PW   = DW + 1 + DW + FRAC;
  localparam logic [DW-1:0] MAXV_L = DW'(MAXV);
  localparam logic [DW-1:0] TMIN_L = DW'(T_MIN);

  typedef struct packed {
    logic [3*DW-1:0] rgb;
    logic            hs;
    logic            vs;
    logic            de;
    logic [DW-1:0]   a;
    logic [1:0]      mode;
    logic [DW-1:0]   dark;
    logic [DW-1:0]   t;
  } pix_t;

  function automatic logic [RW-1:0] recip_f(input int t);
    longint num;
    num = (longint'(MAXV) << FRAC) + longint'(t / 2);
    if (t == 0) return '1;
    return RW'(num / longint'(t));
  endfunction

  logic [RW-1:0] rom [2**DW];
  for (genvar g = 0; g < 2**DW; g++) begin : g_rom
    assign rom[g] = recip_f(g);
  end

  logic [DW-1:0] atm_q, atm_d, max_q, max_d;
  logic [1:0]    mode_q, mode_d;
  logic          has_q, has_d, vs_q, vs_d;
  logic [DW-1:0] dark_in, rg_min, r_in, g_in, b_in, a_cap;
  logic          fs;

  pix_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic [RW-1:0]        r3_q, r3_d;
  logic signed [PW-1:0] p4_q [3];
  logic signed [PW-1:0] p4_d [3];
  logic signed [PW-1:0] d_ext [3];
  logic signed [PW-1:0] r_ext;
  logic signed [PW:0]   sum_v [3];
  logic [DW-1:0]        j_v [3];
  logic [DW+7:0]        om;
  logic [DW-1:0]        tt;

  logic [3*DW-1:0] orgb_q, orgb_d;
  logic            ohs_q, ovs_q, ode_q;

  // Frame-start detect, running max of dark, per-frame A/mode latch
  always_comb begin
    r_in   = vif.i_rgb[3*DW-1:2*DW];
    g_in   = vif.i_rgb[2*DW-1:DW];
    b_in   = vif.i_rgb[DW-1:0];
    rg_min = (r_in < g_in) ? r_in : g_in;
    dark_in = (rg_min < b_in) ? rg_min : b_in;
    fs     = vif.i_vsync & ~vs_q;
    a_cap  = (max_q < vif.i_thre) ? max_q : vif.i_thre;
    vs_d   = vif.i_vsync;
    atm_d  = atm_q;
    mode_d = mode_q;
    max_d  = max_q;
    has_d  = has_q;
    if (fs) begin
      if (has_q) atm_d = a_cap;
      mode_d = vif.i_mode;
      max_d  = vif.i_de ? dark_in : '0;
      has_d  = vif.i_de;
    end else if (vif.i_de) begin
      if (dark_in > max_q) max_d = dark_in;
      has_d = 1'b1;
    end
  end

  // Stages 1-3: capture with frame A/mode, transmittance, reciprocal
  always_comb begin
    s1_d      = '0;
    s1_d.rgb  = vif.i_rgb;
    s1_d.hs   = vif.i_hsync;
    s1_d.vs   = vif.i_vsync;
    s1_d.de   = vif.i_de;
    s1_d.a    = atm_d;
    s1_d.mode = mode_d;
    s1_d.dark = dark_in;
    om   = (DW+8)'(s1_q.dark) * (DW+8)'(OMEGA_Q8);
    tt   = MAXV_L - om[DW+7:8];
    s2_d = s1_q;
    s2_d.t = (tt < TMIN_L) ? TMIN_L : tt;
    s3_d = s2_q;
    r3_d = rom[s2_q.t];
  end

  // Stage 4: signed (C - A) * R(t) per channel at full width
  always_comb begin
    s4_d  = s3_q;
    r_ext = PW'($signed({1'b0, r3_q}));
    for (int c = 0; c < 3; c++) begin
      d_ext[c] = PW'($signed({1'b0, s3_q.rgb[c*DW +: DW]})
                   - $signed({1'b0, s3_q.a}));
      p4_d[c]  = d_ext[c] * r_ext;
    end
  end

  // Stage 5: recover J with floor shift and saturation, select view
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_v[c] = (PW+1)'(p4_q[c] >>> FRAC)
               + (PW+1)'($signed({1'b0, s4_q.a}));
      if (sum_v[c] < 0)         j_v[c] = '0;
      else if (sum_v[c] > MAXV) j_v[c] = MAXV_L;
      else                      j_v[c] = DW'(sum_v[c]);
    end
    case (s4_q.mode)
      2'd0:    orgb_d = s4_q.rgb;
      2'd1:    orgb_d = {3{s4_q.dark}};
      2'd2:    orgb_d = {3{s4_q.t}};
      default: orgb_d = {j_v[2], j_v[1], j_v[0]};
    endcase
    if (!s4_q.de) orgb_d = '0;
  end

  // All state: frame registers, pipeline stages, output registers
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      atm_q  <= MAXV_L;
      mode_q <= 2'd3;
      max_q  <= '0;
      has_q  <= 1'b0;
      vs_q   <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      s4_q   <= '0;
      r3_q   <= '0;
      p4_q   <= '{default: '0};
      orgb_q <= '0;
      ohs_q  <= 1'b0;
      ovs_q  <= 1'b0;
      ode_q  <= 1'b0;
    end else begin
      atm_q  <= atm_d;
      mode_q <= mode_d;
      max_q  <= max_d;
      has_q  <= has_d;
      vs_q   <= vs_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      r3_q   <= r3_d;
      p4_q   <= p4_d;
      orgb_q <= orgb_d;
      ohs_q  <= s4_q.hs;
      ovs_q  <= s4_q.vs;
      ode_q  <= s4_q.de;
    end
  end

  assign vif.o_rgb   = orgb_q;
  assign vif.o_hsync = ohs_q;
  assign vif.o_vsync = ovs_q;
  assign vif.o_de    = ode_q;
  assign vif.o_atmos = atm_q;
endmodule
